fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Pulls pixels from a synchronous FIFO (one-cycle read latency) into a 2-entry
// skid buffer and presents them as an AXI-Stream video beat with SOF/EOL tags.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 12,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_flush,
   output logic                  o_fifo_rd,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic                  o_tvalid,
   input  logic                  i_tready,
   output logic [DATA_WIDTH-1:0] o_tdata,
   output logic                  o_tuser,
   output logic                  o_tlast,
   output logic                  o_frame_done
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   logic [1:0]            count_reg;
   logic [1:0]            count_next;
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic                  inflight_reg;
   logic [XW-1:0]         x_cnt_reg;
   logic [XW-1:0]         x_cnt_next;
   logic [YW-1:0]         y_cnt_reg;
   logic [YW-1:0]         y_cnt_next;
   logic                  frame_done_reg;
   logic                  beat;
   logic                  push;
   logic                  end_of_frame;
   logic [2:0]            occupancy;
   logic [DATA_WIDTH-1:0] slot_data [2];

   assign o_tvalid = (count_reg != 2'd0);
   assign beat     = o_tvalid & i_tready;
   // Data requested last cycle is on i_fifo_data now; a flush drops it.
   assign push     = inflight_reg & ~i_flush;

   // Words already owned (buffered + arriving) after this cycle's beat leaves.
   assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, beat};
   assign o_fifo_rd = i_rstn & ~i_flush & ~i_fifo_empty & (occupancy < 3'd2);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0] data_reg;

         always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
               data_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
               data_reg <= i_fifo_data;
            end
         end

         assign slot_data[gi] = data_reg;
      end
   endgenerate

   assign o_tdata = slot_data[rd_ptr_reg];

   always_comb begin
      count_next = count_reg + {1'b0, push} - {1'b0, beat};
      x_cnt_next = x_cnt_reg;
      y_cnt_next = y_cnt_reg;
      if (beat) begin
         if (x_cnt_reg == X_LAST) begin
            x_cnt_next = '0;
            if (y_cnt_reg == Y_LAST) begin
               y_cnt_next = '0;
            end else begin
               y_cnt_next = y_cnt_reg + YW'(1);
            end
         end else begin
            x_cnt_next = x_cnt_reg + XW'(1);
         end
      end
   end

   assign end_of_frame = beat & (x_cnt_reg == X_LAST) & (y_cnt_reg == Y_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_flush) begin
         count_reg      <= 2'd0;
         wr_ptr_reg     <= 1'b0;
         rd_ptr_reg     <= 1'b0;
         inflight_reg   <= 1'b0;
         x_cnt_reg      <= '0;
         y_cnt_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         count_reg      <= count_next;
         inflight_reg   <= o_fifo_rd;
         x_cnt_reg      <= x_cnt_next;
         y_cnt_reg      <= y_cnt_next;
         frame_done_reg <= end_of_frame;
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (beat) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   assign o_tuser      = o_tvalid & (x_cnt_reg == '0) & (y_cnt_reg == '0);
   assign o_tlast      = o_tvalid & (x_cnt_reg == X_LAST);
   assign o_frame_done = frame_done_reg;

endmodule
